// File: rtl/mod_n_cascade_counter.sv
// -----------------------------------------------------------------------------
// mod_n_cascade_counter
//
// Parametrised multi-digit modulo-N counter (timebase / event counter for the
// 7-segment display and stopwatch blocks). Each digit counts 0..MODULUS-1 and
// ripples carry (up) or borrow (down) into the next digit.
//
// Parameters:
//   DIGITS  - number of cascaded digits (1..8)
//   MODULUS - count range per digit, 0..MODULUS-1 (2..2^W)
//   W       - bits per digit
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   en       in   count enable, one step per clk while high
//   up       in   direction: 1 = increment, 0 = decrement
//   clear    in   synchronous clear (highest priority)
//   load     in   synchronous parallel load (beats en)
//   load_val in   load value, digit i in bits [i*W +: W], digit 0 LS
//   k        out  current count, same digit packing
//   tc       out  terminal count (combinational), usable as cascade enable
//   wrap     out  registered one-cycle pulse after a full-range wrap
//   load_err out  registered one-cycle pulse after a load with illegal digit
//
// Optional build macro:
//   MOD_N_CASCADE_SATURATE_EN - counter saturates at the limit instead of
//   wrapping; wrap is never asserted, tc still flags the limit.
// -----------------------------------------------------------------------------
module mod_n_cascade_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  parameter int W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DIGITS*W-1:0]   load_val,
  output logic [DIGITS*W-1:0]   k,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  // One extra bit so MODULUS = 2^W is representable in the legality compare.
  localparam logic [W:0]   MOD_V = (W+1)'(MODULUS);
  localparam logic [W-1:0] MAX_D = W'(MODULUS - 1);

  logic [DIGITS-1:0][W-1:0] cnt;
  logic [DIGITS-1:0][W-1:0] step_val;
  logic [DIGITS-1:0][W-1:0] load_fix;
  logic [DIGITS-1:0]        load_bad;
  logic                     all_max;
  logic                     all_zero;
  logic                     ripple;

  function automatic logic legal(input logic [W-1:0] d);
    return {1'b0, d} < MOD_V;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_max  = all_max  & (cnt[i] == MAX_D);
      all_zero = all_zero & (cnt[i] == '0);
    end
  end

  assign tc = en & (up ? all_max : all_zero);

  // Carry/borrow chain: a digit steps only while ripple is still set, i.e.
  // every lower digit was at its roll-over value. An illegal digit is forced
  // to zero and stops the ripple so no spurious carry reaches higher digits.
  always_comb begin
    step_val = cnt;
    ripple   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (!legal(cnt[i])) begin
          step_val[i] = '0;
          ripple      = 1'b0;
        end else if (up) begin
          if (cnt[i] == MAX_D) begin
            step_val[i] = '0;
          end else begin
            step_val[i] = cnt[i] + W'(1);
            ripple      = 1'b0;
          end
        end else begin
          if (cnt[i] == '0) begin
            step_val[i] = MAX_D;
          end else begin
            step_val[i] = cnt[i] - W'(1);
            ripple      = 1'b0;
          end
        end
      end
    end
  end

  // Illegal load digits are replaced by zero and flagged.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      load_bad[i] = !legal(load_val[i*W +: W]);
      load_fix[i] = load_bad[i] ? '0 : load_val[i*W +: W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (clear) begin
      cnt      <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      cnt      <= load_fix;
      wrap     <= 1'b0;
      load_err <= |load_bad;
    end else if (en) begin
      load_err <= 1'b0;
`ifdef MOD_N_CASCADE_SATURATE_EN
      // At the limit tc is high: hold instead of rolling over.
      if (!tc) begin
        cnt <= step_val;
      end
      wrap <= 1'b0;
`else
      cnt  <= step_val;
      wrap <= tc;
`endif
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

  assign k = cnt;

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
module tb_mod_n_cascade_counter;

  localparam int DIGITS  = 2;
  localparam int MODULUS = 10;
  localparam int W       = 4;
  localparam int DW      = DIGITS * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          up;
  logic          clear;
  logic          load;
  logic [DW-1:0] load_val;
  logic [DW-1:0] k;
  logic          tc;
  logic          wrap;
  logic          load_err;

  mod_n_cascade_counter #(.DIGITS(DIGITS), .MODULUS(MODULUS), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .k        (k),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] k;
    logic          wrap;
    logic          lerr;
  } exp_t;

  exp_t    exp_q[$];
  int      checks = 0;
  int      errors = 0;

  // Reference model: the count as one integer in base MODULUS.
  longint  model_val = 0;
  longint  top_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] to_packed(input longint v);
    logic [DW-1:0] p;
    longint        t;
    p = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      p[i*W +: W] = W'(t % MODULUS);
      t = t / MODULUS;
    end
    return p;
  endfunction

  function automatic longint from_load(input logic [DW-1:0] lv, output bit bad);
    longint v;
    longint d;
    v   = 0;
    bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = longint'(lv[i*W +: W]);
      if (d >= MODULUS) begin
        bad = 1'b1;
        d   = 0;
      end
      v = v * MODULUS + d;
    end
    return v;
  endfunction

  // Drive one edge worth of inputs, check tc combinationally, and push the
  // expected post-edge response for the monitor.
  task automatic apply(input bit c, input bit l, input logic [DW-1:0] lv,
                       input bit e, input bit u);
    bit   exp_tc;
    bit   bad;
    exp_t x;
    @(negedge clk);
    clear    = c;
    load     = l;
    load_val = lv;
    en       = e;
    up       = u;
    #1;
    exp_tc = e && (u ? (model_val == top_val - 1) : (model_val == 0));
    check("tc", 64'(tc), 64'(exp_tc));
    x.wrap = 1'b0;
    x.lerr = 1'b0;
    if (c) begin
      model_val = 0;
    end else if (l) begin
      model_val = from_load(lv, bad);
      x.lerr    = bad;
    end else if (e) begin
      if (exp_tc) begin
`ifndef MOD_N_CASCADE_SATURATE_EN
        model_val = u ? 0 : top_val - 1;
        x.wrap    = 1'b1;
`endif
      end else begin
        model_val = u ? model_val + 1 : model_val - 1;
      end
    end
    x.k = to_packed(model_val);
    exp_q.push_back(x);
  endtask

  task automatic ld(input logic [DW-1:0] lv);
    apply(1'b0, 1'b1, lv, 1'b0, 1'b0);
  endtask

  task automatic stepc(input bit u);
    apply(1'b0, 1'b0, '0, 1'b1, u);
  endtask

  // Wait until just after the edge of the last applied stimulus.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Assert reset between edges and check its immediate effect.
  task automatic reset_pulse();
    @(negedge clk);
    clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_val = '0;
    reset = 1'b1;
    #1;
    check("reset_k", 64'(k), 64'(0));
    check("reset_wrap", 64'(wrap), 64'(0));
    check("reset_lerr", 64'(load_err), 64'(0));
    model_val = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every edge with an outstanding expectation is compared.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("k", 64'(k), 64'(x.k));
        check("wrap", 64'(wrap), 64'(x.wrap));
        check("load_err", 64'(load_err), 64'(x.lerr));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    top_val = 1;
    for (int i = 0; i < DIGITS; i++) top_val = top_val * MODULUS;

    reset = 1'b1; en = 1'b0; up = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    #1;
    check("por_k", 64'(k), 64'(0));
    check("por_wrap", 64'(wrap), 64'(0));
    check("por_lerr", 64'(load_err), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-count, then 12 up steps.
    ld(DW'('h37));
    settle();
    check("plan_k37", 64'(k), 64'('h37));
    reset_pulse();
    for (int i = 0; i < 12; i++) stepc(1'b1);
    settle();
    check("plan_k12", 64'(k), 64'('h12));

    // Up wrap from 0x98.
    ld(DW'('h98));
    stepc(1'b1);
    stepc(1'b1);
    settle();
`ifdef MOD_N_CASCADE_SATURATE_EN
    check("plan_sat99", 64'(k), 64'('h99));
`else
    check("plan_wrap00", 64'(k), 64'('h00));
`endif

    // Down wrap from 0x01, then digit borrow from 0x10.
    ld(DW'('h01));
    stepc(1'b0);
    stepc(1'b0);
    ld(DW'('h10));
    stepc(1'b0);
    settle();
    check("plan_borrow09", 64'(k), 64'('h09));

    // Illegal load digits.
    ld(DW'('hA5));
    settle();
    check("plan_ldA5", 64'(k), 64'('h05));
    ld(DW'('h3F));
    settle();
    check("plan_ld3F", 64'(k), 64'('h30));

    // clear beats load and en.
    apply(1'b1, 1'b1, DW'('h55), 1'b1, 1'b1);
    settle();
    check("plan_clear", 64'(k), 64'('h00));

    // Direction toggle every edge, then hold.
    ld(DW'('h50));
    stepc(1'b1);
    stepc(1'b0);
    stepc(1'b1);
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, '0, 1'b0, 1'b1);
    settle();
    check("plan_hold51", 64'(k), 64'('h51));

    // Randomised traffic, biased toward the limits to exercise wrap/tc.
    for (int n = 0; n < 400; n++) begin
      bit            c;
      bit            l;
      bit            e;
      bit            u;
      logic [DW-1:0] lv;
      int            pick;
      c    = ($urandom_range(0, 99) < 4);
      l    = ($urandom_range(0, 99) < 12);
      e    = ($urandom_range(0, 99) < 75);
      u    = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 3);
      if (pick == 0)      lv = to_packed(top_val - 1);
      else if (pick == 1) lv = to_packed(0);
      else                lv = DW'($urandom);
      apply(c, l, lv, e, u);
    end

    // Idle edge then drain the scoreboard.
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    settle();
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
